// File: rtl/updown_step_ctrl_if.sv
// Interface bundle between the host/counter side and updown_step_ctrl.
// The slave modport is the controller's view; the master modport is the
// view of whatever drives commands and hosts the counter.
interface updown_step_ctrl_if #(
  parameter int W = 4
) ();
  logic         start;
  logic [W-1:0] target;
  logic         abort;
  logic [W-1:0] cnt_value;
  logic         cnt_enable;
  logic         cnt_up_down;
  logic         busy;
  logic         done;
  logic         aborted;

  modport slave (
    input  start,
    input  target,
    input  abort,
    input  cnt_value,
    output cnt_enable,
    output cnt_up_down,
    output busy,
    output done,
    output aborted
  );

  modport master (
    output start,
    output target,
    output abort,
    output cnt_value,
    input  cnt_enable,
    input  cnt_up_down,
    input  busy,
    input  done,
    input  aborted
  );
endinterface

// File: rtl/updown_step_ctrl.sv
// updown_step_ctrl: steps an external W-bit up/down counter toward a
// latched target, one step per prescaler tick, then pulses done.
// Optional build macro WRAP_SHORTEST_EN: pick the shorter way around the
// modulo-2^W circle (ties go up) instead of a plain unsigned compare.
module updown_step_ctrl #(
  parameter int W        = 4,
  parameter int STEP_DIV = 2
) (
  input logic              clk_i,
  input logic              reset_i,
  updown_step_ctrl_if.slave ctrl
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MOVE = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0]   TICK_MAX = 8'(STEP_DIV - 1);
  localparam logic [W-1:0] HALF     = W'(1) << (W - 1);

  state_t       state_q, state_d;
  logic [7:0]   presc_q, presc_d;
  logic [W-1:0] target_q, target_d;
  logic         dir_q, dir_d;
  logic         done_q, done_d;
  logic         aborted_q, aborted_d;

  logic         tick_s;
  logic         at_target_s;
  logic         dir_cmd_s;

  // Direction for a fresh command; distance arithmetic wraps modulo 2^W.
  function automatic logic pick_dir(input logic [W-1:0] tgt, input logic [W-1:0] cur);
`ifdef WRAP_SHORTEST_EN
    logic [W-1:0] up_dist;
    up_dist = tgt - cur;
    return (up_dist <= HALF);
`else
    return (tgt > cur);
`endif
  endfunction

  assign tick_s      = (presc_q == TICK_MAX);
  assign at_target_s = (ctrl.cnt_value == target_q);
  assign dir_cmd_s   = pick_dir(ctrl.target, ctrl.cnt_value);

  // Next-state, prescaler and pulse decode for the IDLE/MOVE/DONE sequencer.
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    target_d  = target_q;
    dir_d     = dir_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ctrl.start) begin
          target_d = ctrl.target;
          if (ctrl.target == ctrl.cnt_value) begin
            // Already there: zero-step move goes straight to DONE.
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            dir_d   = dir_cmd_s;
            presc_d = 8'd0;
            state_d = S_MOVE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MOVE: begin
        if (tick_s) begin
          presc_d = 8'd0;
        end else begin
          presc_d = presc_q + 8'd1;
        end
        // Abort outranks arrival; equality is re-checked every cycle.
        if (ctrl.abort) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else if (at_target_s) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_MOVE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      presc_q   <= 8'd0;
      target_q  <= '0;
      dir_q     <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      target_q  <= target_d;
      dir_q     <= dir_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  // Enable is combinational so abort and reset can suppress a step in
  // the same cycle they are raised.
  assign ctrl.cnt_enable  = (state_q == S_MOVE) & tick_s & ~ctrl.abort
                            & ~at_target_s & ~reset_i;
  assign ctrl.cnt_up_down = dir_q;
  assign ctrl.busy        = (state_q == S_MOVE);
  assign ctrl.done        = done_q;
  assign ctrl.aborted     = aborted_q;

endmodule
